ne_window_unit: RTL and testbench

Multi-channel nonlinear-energy (Teager–Kaiser) feature unit and the parametrised successor of the single-channel `ne_comp_unit`. It accepts time-multiplexed samples tagged with a channel index and computes psi[n] = x[n-1]^2 − x[n]·x[n-2] per channel at full precision. In mode 0 it emits psi per sample; in mode 1 it emits non-overlapping window sums of psi per channel. It sits between the per-channel sample front end and the feature/classifier stage.

---
 rtl/ne_window_unit.sv | 167 ++++++++++++++++
 tb/tb_ne_window_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ne_window_unit.sv
// Multi-channel Teager-Kaiser energy unit: psi = x[n-1]^2 - x[n]*x[n-2] per channel,
// emitted per sample (mode 0) or as non-overlapping window sums of 2^win_log2 values (mode 1).
module ne_window_unit #(
    parameter int unsigned input_width = 32,
    parameter int unsigned num_ch      = 4,
    parameter int unsigned win_log2    = 4,
    localparam int unsigned CH_W  = (num_ch > 1) ? $clog2(num_ch) : 1,
    localparam int unsigned OUT_W = 2 * input_width + 1 + win_log2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [input_width-1:0] din,
    input  logic [CH_W-1:0]               ch_in,
    input  logic                          mode,
    input  logic                          clr,
    output logic signed [OUT_W-1:0]       dout,
    output logic [CH_W-1:0]               dout_ch,
    output logic                          data_valid,
    output logic                          ch_err
);

    localparam int unsigned PROD_W = 2 * input_width;
    localparam int unsigned DIFF_W = PROD_W + 1;

    // per-channel history and window state
    logic signed [input_width-1:0] x1   [num_ch];
    logic signed [input_width-1:0] x2   [num_ch];
    logic [1:0]                    fill [num_ch];
    logic signed [OUT_W-1:0]       acc  [num_ch];
    logic [win_log2-1:0]           cnt  [num_ch];

    // S1 registers
    logic                          s1_vld, s1_act, s1_mode;
    logic [CH_W-1:0]               s1_ch;
    logic signed [input_width-1:0] s1_a, s1_b, s1_c;

    // S2 registers
    logic                          s2_vld, s2_act, s2_mode;
    logic [CH_W-1:0]               s2_ch;
    logic signed [PROD_W-1:0]      s2_p1, s2_p2;

    logic                          ch_ok_c, accept_c, bad_c;
    logic signed [DIFF_W-1:0]      psi_c;
    logic signed [OUT_W-1:0]       sum_c;

    always_comb begin
        ch_ok_c  = (32'(ch_in) < num_ch);
        accept_c = en && !clr && ch_ok_c;
        bad_c    = en && !clr && !ch_ok_c;
    end

    // S1: capture, history read and update in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                x1[i]   <= '0;
                x2[i]   <= '0;
                fill[i] <= '0;
            end
            s1_vld  <= 1'b0;
            s1_act  <= 1'b0;
            s1_mode <= 1'b0;
            s1_ch   <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_c    <= '0;
            ch_err  <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                x1[i]   <= '0;
                x2[i]   <= '0;
                fill[i] <= '0;
            end
            s1_vld <= 1'b0;
            s1_act <= 1'b0;
            ch_err <= 1'b0;
        end else begin
            ch_err <= bad_c;
            s1_act <= accept_c;
            s1_vld <= accept_c && (fill[ch_in] == 2'd2);
            if (accept_c) begin
                s1_a        <= din;
                s1_b        <= x1[ch_in];
                s1_c        <= x2[ch_in];
                s1_ch       <= ch_in;
                s1_mode     <= mode;
                x1[ch_in]   <= din;
                x2[ch_in]   <= x1[ch_in];
                if (fill[ch_in] != 2'd2) begin
                    fill[ch_in] <= fill[ch_in] + 2'd1;
                end
            end
        end
    end

    // S2: full-precision products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld  <= 1'b0;
            s2_act  <= 1'b0;
            s2_mode <= 1'b0;
            s2_ch   <= '0;
            s2_p1   <= '0;
            s2_p2   <= '0;
        end else if (clr) begin
            s2_vld <= 1'b0;
            s2_act <= 1'b0;
        end else begin
            s2_vld  <= s1_vld;
            s2_act  <= s1_act;
            s2_mode <= s1_mode;
            s2_ch   <= s1_ch;
            s2_p1   <= PROD_W'(s1_b) * PROD_W'(s1_b);
            s2_p2   <= PROD_W'(s1_a) * PROD_W'(s1_c);
        end
    end

    always_comb begin
        psi_c = DIFF_W'(s2_p1) - DIFF_W'(s2_p2);
        sum_c = acc[s2_ch] + OUT_W'(psi_c);
    end

    // S3: subtract, accumulate, register outputs; any mode-0 sample flushes all windows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            dout       <= '0;
            dout_ch    <= '0;
            data_valid <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (s2_act && !s2_mode) begin
                for (int unsigned i = 0; i < num_ch; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
                if (s2_vld) begin
                    dout       <= OUT_W'(psi_c);
                    dout_ch    <= s2_ch;
                    data_valid <= 1'b1;
                end
            end else if (s2_vld && s2_mode) begin
                if (&cnt[s2_ch]) begin
                    dout       <= sum_c;
                    dout_ch    <= s2_ch;
                    data_valid <= 1'b1;
                    acc[s2_ch] <= '0;
                    cnt[s2_ch] <= '0;
                end else begin
                    acc[s2_ch] <= sum_c;
                    cnt[s2_ch] <= cnt[s2_ch] + win_log2'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ne_window_unit.sv
// Directed self-checking bench for ne_window_unit (32-bit samples, 5 channels, window of 4).
module tb_ne_window_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned NCH   = 5;
    localparam int unsigned WL2   = 2;
    localparam int unsigned CHW   = 3;
    localparam int unsigned OUTW  = 2 * W + 1 + WL2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic signed [W-1:0]    din;
    logic [CHW-1:0]         ch_in;
    logic                   mode;
    logic                   clr;
    logic signed [OUTW-1:0] dout;
    logic [CHW-1:0]         dout_ch;
    logic                   data_valid;
    logic                   ch_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_cap = 0;
    int err_cnt  = 0;
    logic md = 1'b0;

    logic signed [OUTW-1:0] q_d   [$];
    logic [CHW-1:0]         q_ch  [$];
    int                     q_cyc [$];

    ne_window_unit #(.input_width(W), .num_ch(NCH), .win_log2(WL2)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .ch_in(ch_in), .mode(mode),
        .clr(clr), .dout(dout), .dout_ch(dout_ch), .data_valid(data_valid), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // collect results away from the active edge
    always @(negedge clk) begin
        if (data_valid) begin
            q_d.push_back(dout);
            q_ch.push_back(dout_ch);
            q_cyc.push_back(cyc);
        end
        if (ch_err) err_cnt++;
    end

    task automatic put(input logic [CHW-1:0] c, input logic signed [W-1:0] d);
        @(negedge clk);
        en = 1'b1; ch_in = c; din = d; mode = md; clr = 1'b0;
        last_cap = cyc + 1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        en = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic flush_q();
        q_d.delete(); q_ch.delete(); q_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; din = '0; ch_in = '0; mode = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %0d want 0", dout); end
        n_cmp++; if (dout_ch !== '0) begin n_bad++; $display("FAIL reset_dout_ch: got %0d want 0", dout_ch); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_cmp++; if (ch_err !== 1'b0) begin n_bad++; $display("FAIL reset_ch_err: got %b want 0", ch_err); end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int cap3;
        flush_q(); md = 1'b0;
        put(0, 1); put(0, 2);
        put(0, 3); cap3 = last_cap;
        idle(6);
        n_cmp++; if (q_d.size() !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", q_d.size()); end
        if (q_d.size() >= 1) begin
            n_cmp++; if (q_d[0] !== 67'sd1) begin n_bad++; $display("FAIL basic_dout: got %0d want 1", q_d[0]); end
            n_cmp++; if (q_ch[0] !== 3'd0) begin n_bad++; $display("FAIL basic_ch: got %0d want 0", q_ch[0]); end
            n_cmp++; if (q_cyc[0] !== cap3 + 2) begin n_bad++; $display("FAIL basic_latency: got cycle %0d want %0d", q_cyc[0], cap3 + 2); end
        end
    endtask

    task automatic test_interleave();
        clr_pulse(); flush_q(); md = 1'b0;
        put(0, 1); put(1, 10); put(0, 2); put(1, 20); put(0, 3); put(1, 30);
        idle(6);
        n_cmp++; if (q_d.size() !== 2) begin n_bad++; $display("FAIL inter_count: got %0d want 2", q_d.size()); end
        if (q_d.size() >= 2) begin
            n_cmp++; if (q_d[0] !== 67'sd1 || q_ch[0] !== 3'd0) begin n_bad++; $display("FAIL inter_first: got %0d ch %0d want 1 ch 0", q_d[0], q_ch[0]); end
            n_cmp++; if (q_d[1] !== 67'sd100 || q_ch[1] !== 3'd1) begin n_bad++; $display("FAIL inter_second: got %0d ch %0d want 100 ch 1", q_d[1], q_ch[1]); end
            n_cmp++; if (q_cyc[1] !== q_cyc[0] + 1) begin n_bad++; $display("FAIL inter_spacing: got cycle %0d want %0d", q_cyc[1], q_cyc[0] + 1); end
        end
    endtask

    task automatic test_signs();
        logic signed [W-1:0]    v [4][3];
        logic signed [OUTW-1:0] e [4];
        string nm [4];
        v[0][0] = -32'sd100;        v[0][1] = 32'sd0;          v[0][2] = 32'sd100;        e[0] = 67'sd10000;               nm[0] = "signs_pos";
        v[1][0] = 32'sd0;           v[1][1] = 32'sh80000000;   v[1][2] = 32'sh7fffffff;   e[1] = 67'sd4611686018427387904; nm[1] = "signs_2p62";
        v[2][0] = 32'sh80000000;    v[2][1] = 32'sh80000000;   v[2][2] = 32'sh80000000;   e[2] = 67'sd0;                   nm[2] = "signs_minx3";
        v[3][0] = 32'sd1;           v[3][1] = 32'sd0;          v[3][2] = 32'sd5;          e[3] = -67'sd5;                  nm[3] = "signs_neg";
        md = 1'b0;
        for (int t = 0; t < 4; t++) begin
            clr_pulse(); flush_q();
            put(2, v[t][0]); put(2, v[t][1]); put(2, v[t][2]);
            idle(6);
            n_cmp++;
            if (q_d.size() !== 1 || q_d[0] !== e[t] || q_ch[0] !== 3'd2) begin
                n_bad++;
                $display("FAIL %s: got %0d results first %0d want one result %0d on ch 2", nm[t], q_d.size(), (q_d.size() > 0) ? q_d[0] : 67'sd0, e[t]);
            end
        end
    endtask

    task automatic test_window();
        int cap;
        clr_pulse(); flush_q(); md = 1'b1;
        for (int i = 1; i <= 6; i++) begin put(0, W'(i)); cap = last_cap; end
        idle(6);
        n_cmp++; if (q_d.size() !== 1) begin n_bad++; $display("FAIL win_count1: got %0d want 1", q_d.size()); end
        if (q_d.size() >= 1) begin
            n_cmp++; if (q_d[0] !== 67'sd4) begin n_bad++; $display("FAIL win_sum1: got %0d want 4", q_d[0]); end
            n_cmp++; if (q_cyc[0] !== cap + 2) begin n_bad++; $display("FAIL win_when1: got cycle %0d want %0d", q_cyc[0], cap + 2); end
        end
        for (int i = 7; i <= 10; i++) put(0, W'(i));
        idle(6);
        n_cmp++; if (q_d.size() !== 2) begin n_bad++; $display("FAIL win_count2: got %0d want 2", q_d.size()); end
        if (q_d.size() >= 2) begin
            n_cmp++; if (q_d[1] !== 67'sd4 || q_ch[1] !== 3'd0) begin n_bad++; $display("FAIL win_sum2: got %0d ch %0d want 4 ch 0", q_d[1], q_ch[1]); end
        end
        md = 1'b0;
    endtask

    task automatic test_mode_switch();
        int cap9;
        clr_pulse(); flush_q();
        md = 1'b1;
        for (int i = 1; i <= 4; i++) put(0, W'(i));
        md = 1'b0; put(0, 5);
        md = 1'b1;
        for (int i = 6; i <= 9; i++) begin put(0, W'(i)); cap9 = last_cap; end
        idle(6);
        md = 1'b0;
        n_cmp++; if (q_d.size() !== 2) begin n_bad++; $display("FAIL mode_count: got %0d want 2", q_d.size()); end
        if (q_d.size() >= 2) begin
            n_cmp++; if (q_d[0] !== 67'sd1) begin n_bad++; $display("FAIL mode_psi: got %0d want 1", q_d[0]); end
            n_cmp++; if (q_d[1] !== 67'sd4 || q_cyc[1] !== cap9 + 2) begin n_bad++; $display("FAIL mode_fresh_win: got %0d at cycle %0d want 4 at %0d", q_d[1], q_cyc[1], cap9 + 2); end
        end
    endtask

    task automatic test_clr();
        clr_pulse(); flush_q(); md = 1'b0;
        put(0, 5); put(0, 6);
        clr_pulse();
        put(0, 7);
        idle(6);
        n_cmp++; if (q_d.size() !== 0) begin n_bad++; $display("FAIL clr_reprime: got %0d results want 0", q_d.size()); end
        clr_pulse(); flush_q();
        put(0, 1); put(0, 2); put(0, 3);
        clr_pulse();
        idle(6);
        n_cmp++; if (q_d.size() !== 0) begin n_bad++; $display("FAIL clr_inflight: got %0d results want 0", q_d.size()); end
    endtask

    task automatic test_ch_err();
        clr_pulse(); flush_q(); md = 1'b0;
        put(0, 1); put(0, 2); put(5, 99); put(0, 3);
        idle(6);
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL ch_err_count: got %0d want 1", err_cnt); end
        n_cmp++; if (q_d.size() !== 1 || q_d[0] !== 67'sd1 || q_ch[0] !== 3'd0) begin
            n_bad++; $display("FAIL ch_err_data: got %0d results first %0d want one result 1 on ch 0", q_d.size(), (q_d.size() > 0) ? q_d[0] : 67'sd0);
        end
    endtask

    task automatic test_reset_mid();
        clr_pulse(); flush_q(); md = 1'b0;
        put(3, 1); put(3, 2); put(3, 3);
        @(negedge clk);
        en = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dout !== '0 || dout_ch !== '0 || data_valid !== 1'b0 || ch_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_outputs: got dout %0d ch %0d v %b e %b want all 0", dout, dout_ch, data_valid, ch_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        put(3, 4); put(3, 5);
        idle(6);
        n_cmp++; if (q_d.size() !== 0) begin n_bad++; $display("FAIL rst_mid_reprime: got %0d results want 0", q_d.size()); end
        put(3, 6);
        idle(6);
        n_cmp++; if (q_d.size() !== 1 || q_d[0] !== 67'sd1 || q_ch[0] !== 3'd3) begin
            n_bad++; $display("FAIL rst_mid_after: got %0d results first %0d want one result 1 on ch 3", q_d.size(), (q_d.size() > 0) ? q_d[0] : 67'sd0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_signs();
        test_window();
        test_mode_switch();
        test_clr();
        test_ch_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
